// File: rtl/cmd_packet_pkg.sv
// Shared constants, state encoding and packet-length helpers for cmd_packet_tx.
// CMD_PACKET_TX_CHECKSUM_EN adds one trailing XOR checksum byte to every packet.
package cmd_packet_pkg;

   localparam logic [7:0] CMD_FREQ_DEF = 8'h0A;
   localparam logic [7:0] CMD_DATA_DEF = 8'h0B;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT,
      ST_FINISH
   } state_e;

   // Control byte layout: {channel[3:0], 1'b0, mode, 2'b01}
   localparam int unsigned CTRL_CH_LSB   = 4;
   localparam int unsigned CTRL_MODE_BIT = 2;
   localparam logic [1:0]  CTRL_TAG      = 2'b01;

   localparam int unsigned HDR_LEN      = 1;
   localparam int unsigned FREQ_TRL_LEN = 2;
   localparam int unsigned DATA_TRL_LEN = 1;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
   localparam int unsigned CSUM_LEN     = 1;
`else
   localparam int unsigned CSUM_LEN     = 0;
`endif

   function automatic int unsigned pkt_len(input int unsigned data_bit, input logic is_data);
      return HDR_LEN + data_bit / 8 + (is_data ? DATA_TRL_LEN : FREQ_TRL_LEN) + CSUM_LEN;
   endfunction

endpackage

// File: rtl/cmd_packet_tx.sv
// Serialises frequency/data command packets into a byte-wide UART transmitter.
// Define CMD_PACKET_TX_CHECKSUM_EN to append an XOR checksum byte to each packet.
module cmd_packet_tx
   import cmd_packet_pkg::*;
#(
   parameter int unsigned DATA_BIT = 32,
   parameter logic [7:0]  CMD_FREQ = CMD_FREQ_DEF,
   parameter logic [7:0]  CMD_DATA = CMD_DATA_DEF
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_type_i,
   input  logic [DATA_BIT-1:0] pattern_i,
   input  logic [3:0]          channel_i,
   input  logic                mode_i,
   input  logic [7:0]          slow_period_i,
   input  logic [7:0]          fast_period_i,
   output logic                tx_start_o,
   output logic [7:0]          tx_data_o,
   input  logic                tx_done_tick_i,
   output logic                busy_o,
   output logic                done_tick_o
);

   localparam int unsigned NB      = DATA_BIT / 8;
   localparam int unsigned MAX_LEN = HDR_LEN + NB + FREQ_TRL_LEN + CSUM_LEN;
   localparam int unsigned CW      = $clog2(MAX_LEN);

   state_e                state;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         last_q;
   logic                  type_q;
   logic [DATA_BIT-1:0]   pat_q;
   logic [3:0]            ch_q;
   logic                  mode_q;
   logic [7:0]            slow_q;
   logic [7:0]            fast_q;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   int unsigned           nxt_idx;
   logic [7:0]            ctrl_byte;
   logic [7:0]            nxt_byte;

   // Byte that follows the one currently in flight (index cnt+1 of the packet).
   always_comb begin
      ctrl_byte                  = '0;
      ctrl_byte[CTRL_CH_LSB +: 4] = ch_q;
      ctrl_byte[CTRL_MODE_BIT]   = mode_q;
      ctrl_byte[1:0]             = CTRL_TAG;

      nxt_idx  = 32'(cnt) + 1;
      nxt_byte = '0;
      if (nxt_idx <= NB) begin
         nxt_byte = 8'(pat_q >> ((NB - nxt_idx) * 8));
      end else if (type_q) begin
         if (nxt_idx == NB + 1) nxt_byte = ctrl_byte;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
         else                   nxt_byte = csum_q;
`endif
      end else begin
         if (nxt_idx == NB + 1)      nxt_byte = slow_q;
         else if (nxt_idx == NB + 2) nxt_byte = fast_q;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
         else                        nxt_byte = csum_q;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         last_q      <= '0;
         type_q      <= 1'b0;
         pat_q       <= '0;
         ch_q        <= '0;
         mode_q      <= 1'b0;
         slow_q      <= '0;
         fast_q      <= '0;
         tx_start_o  <= 1'b0;
         tx_data_o   <= '0;
         done_tick_o <= 1'b0;
         busy_o      <= 1'b0;
         req_ready_o <= 1'b0;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         tx_start_o  <= 1'b0;
         done_tick_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               req_ready_o <= 1'b1;
               busy_o      <= 1'b0;
               if (req_valid_i && req_ready_o) begin
                  type_q      <= req_type_i;
                  pat_q       <= pattern_i;
                  ch_q        <= channel_i;
                  mode_q      <= mode_i;
                  slow_q      <= slow_period_i;
                  fast_q      <= fast_period_i;
                  cnt         <= '0;
                  last_q      <= CW'(pkt_len(DATA_BIT, req_type_i) - 1);
                  tx_data_o   <= req_type_i ? CMD_DATA : CMD_FREQ;
                  tx_start_o  <= 1'b1;
                  req_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  state       <= ST_START;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
                  csum_q      <= req_type_i ? CMD_DATA : CMD_FREQ;
`endif
               end
            end
            // The final byte waits in FINISH so its tick can retire straight to IDLE.
            ST_START: state <= (cnt == last_q) ? ST_FINISH : ST_WAIT;
            ST_WAIT: begin
               if (tx_done_tick_i) begin
                  cnt        <= cnt + 1'b1;
                  tx_data_o  <= nxt_byte;
                  tx_start_o <= 1'b1;
                  state      <= ST_START;
`ifdef CMD_PACKET_TX_CHECKSUM_EN
                  csum_q     <= csum_q ^ nxt_byte;
`endif
               end
            end
            ST_FINISH: begin
               if (tx_done_tick_i) begin
                  done_tick_o <= 1'b1;
                  req_ready_o <= 1'b1;
                  busy_o      <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_packet_tx.sv
// Randomised bench for cmd_packet_tx: a UART responder collects bytes, and a
// queue-based packet model built from the byte-order rules supplies expectations.
module tb_cmd_packet_tx;

   localparam int unsigned DATA_BIT = 32;
   localparam int          NB       = DATA_BIT / 8;
   localparam logic [7:0]  OP_FREQ  = 8'h0A;
   localparam logic [7:0]  OP_DATA  = 8'h0B;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_type = 1'b0;
   logic [31:0] pattern = '0;
   logic [3:0]  channel = '0;
   logic        mode = 1'b0;
   logic [7:0]  slow = '0;
   logic [7:0]  fast = '0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        uart_tick = 1'b0;
   logic        spur_tick = 1'b0;
   logic        tx_done_tick;
   logic        busy;
   logic        done_tick;

   assign tx_done_tick = uart_tick | spur_tick;

   cmd_packet_tx #(
      .DATA_BIT(DATA_BIT),
      .CMD_FREQ(OP_FREQ),
      .CMD_DATA(OP_DATA)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_type_i    (req_type),
      .pattern_i     (pattern),
      .channel_i     (channel),
      .mode_i        (mode),
      .slow_period_i (slow),
      .fast_period_i (fast),
      .tx_start_o    (tx_start),
      .tx_data_o     (tx_data),
      .tx_done_tick_i(tx_done_tick),
      .busy_o        (busy),
      .done_tick_o   (done_tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass = 0;
   int hold_err = 0;
   int overlap_err = 0;
   int done_err = 0;
   int done_cnt = 0;
   int start_cnt = 0;
   int pkts_expected = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   // Packet model: opcode, pattern MSB..LSB, trailer, optional XOR of everything before.
   task automatic build_pkt(input logic typ, input logic [31:0] pat, input logic [3:0] ch,
                            input logic md, input logic [7:0] sl, input logic [7:0] fs);
      logic [7:0] b[$];
      logic [7:0] x;
      b.push_back(typ ? OP_DATA : OP_FREQ);
      for (int i = NB - 1; i >= 0; i--) b.push_back(8'(pat >> (8 * i)));
      if (typ) b.push_back({ch, 1'b0, md, 2'b01});
      else begin
         b.push_back(sl);
         b.push_back(fs);
      end
`ifdef CMD_PACKET_TX_CHECKSUM_EN
      x = '0;
      foreach (b[i]) x ^= b[i];
      b.push_back(x);
`else
      x = '0;
`endif
      foreach (b[i]) exp_q.push_back(b[i]);
      pkts_expected++;
   endtask

   // UART stand-in: latch each started byte, hold for a random time, then tick.
   initial begin
      int  lat;
      bit  aborted;
      logic [7:0] cur;
      @(negedge clk);
      forever begin
         if (rst_n && tx_start) begin
            cur = tx_data;
            got.push_back(cur);
            lat = $urandom_range(1, 5);
            aborted = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1'b1;
                  break;
               end
               if (tx_data !== cur) hold_err++;
               if (tx_start) overlap_err++;
            end
            if (!aborted) begin
               uart_tick = 1'b1;
               @(negedge clk);
               uart_tick = 1'b0;
            end
         end else begin
            @(negedge clk);
         end
      end
   end

   always @(negedge clk) begin
      if (tx_start) start_cnt++;
      if (done_tick) begin
         done_cnt++;
         if (busy || !req_ready) done_err++;
      end
   end

   task automatic scramble_inputs();
      req_type = 1'($urandom);
      pattern  = $urandom;
      channel  = 4'($urandom);
      mode     = 1'($urandom);
      slow     = 8'($urandom);
      fast     = 8'($urandom);
   endtask

   task automatic apply_req(input logic typ, input logic [31:0] pat, input logic [3:0] ch,
                            input logic md, input logic [7:0] sl, input logic [7:0] fs);
      int waited = 0;
      while (!req_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      check("ready_before_req", 32'(req_ready), 1);
      req_valid = 1'b1;
      req_type = typ; pattern = pat; channel = ch; mode = md; slow = sl; fast = fs;
      build_pkt(typ, pat, ch, md, sl, fs);
      @(negedge clk);
      req_valid = 1'b0;
      scramble_inputs();
      check("start_after_accept", 32'(tx_start), 1);
      check("busy_after_accept", 32'({req_ready, busy}), 32'b01);
   endtask

   task automatic compare_pkt(input string tag);
      check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < got.size()) check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
      got.delete();
      exp_q.delete();
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done_tick) begin
            seen = 1'b1;
            break;
         end
      end
      check({tag, "_done_seen"}, 32'(seen), 1);
      if (seen) begin
         @(negedge clk);
         check({tag, "_done_one_cycle"}, 32'(done_tick), 0);
      end
      compare_pkt(tag);
   endtask

   initial begin
      int  s0, d0;
      bit  act, early;
      @(negedge clk);
      @(negedge clk);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_done", 32'(done_tick), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'({req_ready, busy}), 32'b10);

      apply_req(1'b0, 32'h11223344, 4'($urandom), 1'($urandom), 8'h14, 8'h05);
      wait_done("freq_dir");
      apply_req(1'b1, 32'h55555555, 4'hF, 1'b1, 8'($urandom), 8'($urandom));
      wait_done("data_dir");

      for (int n = 0; n < 10; n++) begin
         apply_req(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
         wait_done("rand");
      end

      // Valid held high across two requests.
      req_valid = 1'b1;
      req_type = 1'b0; pattern = $urandom; slow = 8'($urandom); fast = 8'($urandom);
      build_pkt(req_type, pattern, channel, mode, slow, fast);
      @(negedge clk);
      req_type = 1'b1; pattern = $urandom; channel = 4'($urandom); mode = 1'($urandom);
      build_pkt(req_type, pattern, channel, mode, slow, fast);
      early = 1'b0;
      act = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done_tick) begin
            act = 1'b1;
            break;
         end
         if (req_ready) early = 1'b1;
      end
      check("b2b_first_done", 32'(act), 1);
      check("b2b_no_early_ready", 32'(early), 0);
      @(negedge clk);
      req_valid = 1'b0;
      scramble_inputs();
      check("b2b_second_start", 32'(tx_start), 1);
      wait_done("b2b");

      // Spurious ticks while idle.
      s0 = start_cnt;
      d0 = done_cnt;
      act = 1'b0;
      for (int i = 0; i < 8; i++) begin
         spur_tick = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (busy || !req_ready || tx_start || done_tick) act = 1'b1;
      end
      spur_tick = 1'b0;
      check("spur_idle_quiet", 32'(act), 0);
      check("spur_no_start", 32'(start_cnt), 32'(s0));
      check("spur_no_done", 32'(done_cnt), 32'(d0));

      // Reset pulse after the third byte has started.
      apply_req(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      for (int i = 0; i < 200 && got.size() < 3; i++) @(negedge clk);
      check("rst_mid_third_byte", 32'(got.size()), 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_outputs", 32'({tx_start, tx_data, done_tick, busy, req_ready}), 0);
      s0 = start_cnt;
      d0 = done_cnt;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_rst_ready_after", 32'({req_ready, busy}), 32'b10);
      for (int i = 0; i < 20; i++) @(negedge clk);
      check("mid_rst_no_start", 32'(start_cnt), 32'(s0));
      check("mid_rst_no_done", 32'(done_cnt), 32'(d0));
      check("mid_rst_bytes", 32'(got.size()), 3);
      got.delete();
      exp_q.delete();
      pkts_expected--;

      apply_req(1'b0, 32'h11223344, 4'h0, 1'b0, 8'h14, 8'h05);
      wait_done("recover");

      check("byte_hold", 32'(hold_err), 0);
      check("start_overlap", 32'(overlap_err), 0);
      check("done_while_busy", 32'(done_err), 0);
      check("done_count", 32'(done_cnt), 32'(pkts_expected));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
